// File: rtl/mmio_pkg.sv
// Shared register map, CTRL/STATUS bit positions and address decode helper
// for the memory-mapped timer/GPIO responder.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

    // Word offsets (A[4:2]) within the 32-byte register window
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_GPIO_OUT = 3'd5;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    localparam int unsigned STATUS_MATCH = 0;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the active-low
// asynchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mmio_timer_responder.sv
// Data-bus responder: prescaled 32-bit timer with compare match, sticky
// MATCH flag and interrupt, plus a GPIO output/input register pair.
module mmio_timer_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              WE,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic              hit,
    output logic              irq,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);

    logic [2:0] word_off;
    logic       wr_en;
    logic       wr_ctrl;
    logic       wr_prescale;
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       wr_gpio_out;

    logic [2:0]        ctrl_q,     ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [15:0]       pre_cnt_q,  pre_cnt_d;
    logic [31:0]       count_q,    count_d;
    logic [31:0]       compare_q,  compare_d;
    logic              match_q,    match_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] gpio_in_sync;

    logic       tick;
    logic       cmp_hit;
    logic       match_set;
    logic [31:0] rd_data;

    // Byte lanes are ignored; all registers are word-wide
    logic unused_byte_lane;
    assign unused_byte_lane = ^A[1:0];

    assign hit      = in_window(A, BASE_ADDR);
    assign word_off = A[4:2];
    assign wr_en    = WE && hit;

    always_comb begin
        wr_ctrl     = 1'b0;
        wr_prescale = 1'b0;
        wr_count    = 1'b0;
        wr_compare  = 1'b0;
        wr_status   = 1'b0;
        wr_gpio_out = 1'b0;
        if (wr_en) begin
            unique case (word_off)
                OFF_CTRL:     wr_ctrl     = 1'b1;
                OFF_PRESCALE: wr_prescale = 1'b1;
                OFF_COUNT:    wr_count    = 1'b1;
                OFF_COMPARE:  wr_compare  = 1'b1;
                OFF_STATUS:   wr_status   = 1'b1;
                OFF_GPIO_OUT: wr_gpio_out = 1'b1;
                OFF_GPIO_IN:  ;
                OFF_RSVD:     ;
            endcase
        end
    end

    assign tick      = ctrl_q[CTRL_EN] && (pre_cnt_q == prescale_q);
    assign cmp_hit   = (count_q == compare_q);
    assign match_set = tick && cmp_hit;

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        gpio_out_d = gpio_out_q;

        if (!ctrl_q[CTRL_EN] || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end

        if (tick) begin
            if (cmp_hit && ctrl_q[CTRL_AUTO_RELOAD]) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_ctrl) begin
            ctrl_d = WD[2:0];
        end
        if (wr_prescale) begin
            prescale_d = WD[15:0];
            pre_cnt_d  = '0;
        end
        // Software write wins over the tick; the match on the old value still counts
        if (wr_count) begin
            count_d = WD;
        end
        if (wr_compare) begin
            compare_d = WD;
        end
        if (wr_status && WD[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
        if (match_set) begin
            match_d = 1'b1;
        end
        if (wr_gpio_out) begin
            gpio_out_d = WD[GPIO_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_q    <= '0;
            compare_q  <= COMPARE_RESET;
            match_q    <= 1'b0;
            gpio_out_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    sync_2ff #(
        .WIDTH(GPIO_W)
    ) u_gpio_in_sync (
        .clk    (clk),
        .areset (areset),
        .d      (gpio_in),
        .q      (gpio_in_sync)
    );

    always_comb begin
        rd_data = '0;
        if (hit) begin
            unique case (word_off)
                OFF_CTRL:     rd_data = {29'd0, ctrl_q};
                OFF_PRESCALE: rd_data = {16'd0, prescale_q};
                OFF_COUNT:    rd_data = count_q;
                OFF_COMPARE:  rd_data = compare_q;
                OFF_STATUS:   rd_data = 32'(match_q);
                OFF_GPIO_OUT: rd_data = 32'(gpio_out_q);
                OFF_GPIO_IN:  rd_data = 32'(gpio_in_sync);
                OFF_RSVD:     rd_data = '0;
            endcase
        end
    end

    assign RD       = rd_data;
    assign irq      = match_q && ctrl_q[CTRL_IRQ_EN];
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboard bench for mmio_timer_responder: expectations are queued when
// stimulus is applied and popped when the bus is sampled.
module tb_mmio_timer_responder;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned GW   = 8;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          WE = 1'b0;
    logic [31:0]   A = '0;
    logic [31:0]   WD = '0;
    logic [31:0]   RD;
    logic          hit;
    logic          irq;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_in = '0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mmio_timer_responder #(
        .BASE_ADDR (BASE),
        .GPIO_W    (GW)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .WE       (WE),
        .A        (A),
        .WD       (WD),
        .RD       (RD),
        .hit      (hit),
        .irq      (irq),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    function automatic logic [31:0] reg_addr(input logic [2:0] off);
        return BASE + {27'd0, off, 2'b00};
    endfunction

    task automatic push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge; the store commits on the next edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        WE = 1'b1;
        A  = addr;
        WD = data;
        @(posedge clk);
        #1;
        WE = 1'b0;
        A  = '0;
        WD = '0;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        A = addr;
        #1;
        data = RD;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] got;
        logic [31:0] rst_vals [8];
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) push($sformatf("reset_reg_%0d", i), rst_vals[i]);
        push("reset_irq", 32'h0);
        push("reset_gpio_out", 32'h0);
        for (int i = 0; i < 8; i++) begin
            peek(reg_addr(3'(i)), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({31'd0, irq} !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (32'(gpio_out) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, gpio_out, e.val);
        end
    endtask

    task automatic test_outside();
        exp_t        e;
        logic [31:0] got;
        logic [31:0] addrs [4];
        logic [31:0] hits  [4];
        logic [31:0] rds   [4];
        addrs = '{32'h0000_2000, 32'h0000_0FFC, 32'h0000_101C, 32'h0000_100F};
        hits  = '{32'h0, 32'h0, 32'h1, 32'h1};
        rds   = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            push($sformatf("hit_%0h", addrs[i]), hits[i]);
            push($sformatf("rd_%0h", addrs[i]), rds[i]);
            peek(addrs[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if ({31'd0, hit} !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, hit, e.val);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // A store outside the window must not land in COUNT
        wr(32'h0000_2008, 32'd123);
        push("outside_write_ignored", 32'h0);
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
    endtask

    task automatic test_prescale();
        exp_t        e;
        logic [31:0] got;
        wr(reg_addr(OFF_PRESCALE), 32'd3);
        wr(reg_addr(OFF_COMPARE), 32'd5);
        wr(reg_addr(OFF_CTRL), 32'd5);
        for (int n = 1; n <= 24; n++) begin
            push($sformatf("prescale_count_edge%0d", n), 32'(n / 4));
            step(1);
            peek(reg_addr(OFF_COUNT), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            if (n >= 23) begin
                push($sformatf("prescale_status_edge%0d", n), (n == 24) ? 32'h1 : 32'h0);
                push($sformatf("prescale_irq_edge%0d", n), (n == 24) ? 32'h1 : 32'h0);
                peek(reg_addr(OFF_STATUS), got);
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
                e = exp_q.pop_front();
                n_checks++;
                if ({31'd0, irq} !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
                end
            end
        end
    endtask

    task automatic test_autoreload_w1c();
        exp_t        e;
        logic [31:0] got;
        wr(reg_addr(OFF_CTRL), 32'd0);
        wr(reg_addr(OFF_STATUS), 32'd1);
        wr(reg_addr(OFF_COUNT), 32'd0);
        wr(reg_addr(OFF_PRESCALE), 32'd0);
        wr(reg_addr(OFF_COMPARE), 32'd2);
        wr(reg_addr(OFF_CTRL), 32'd3);
        for (int n = 0; n < 6; n++) begin
            if (n > 0) step(1);
            push($sformatf("reload_count_%0d", n), 32'(n % 3));
            peek(reg_addr(OFF_COUNT), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // COUNT==COMPARE now: the W1C lands on a match tick and must lose
        wr(reg_addr(OFF_STATUS), 32'd1);
        push("w1c_on_match_status", 32'h1);
        push("w1c_on_match_count", 32'h0);
        wr(reg_addr(OFF_STATUS), 32'd1);
        push("w1c_clear_status", 32'h0);
        push("w1c_clear_count", 32'h1);
        // Second W1C already committed; reading back both results now is only valid for the last
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        peek(reg_addr(OFF_STATUS), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        wr(reg_addr(OFF_CTRL), 32'd0);
    endtask

    task automatic test_w1c_race();
        exp_t        e;
        logic [31:0] got;
        wr(reg_addr(OFF_STATUS), 32'd1);
        wr(reg_addr(OFF_COUNT), 32'd1);
        wr(reg_addr(OFF_COMPARE), 32'd2);
        wr(reg_addr(OFF_CTRL), 32'd3);
        step(1);
        // COUNT is 2 here, so the store below commits on a match tick
        wr(reg_addr(OFF_STATUS), 32'd1);
        push("race_status_kept", 32'h1);
        push("race_count_reloaded", 32'h0);
        peek(reg_addr(OFF_STATUS), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        wr(reg_addr(OFF_CTRL), 32'd0);
    endtask

    task automatic test_wrap_priority();
        exp_t        e;
        logic [31:0] got;
        logic [31:0] exp_cnt [5];
        logic [31:0] exp_st  [5];
        wr(reg_addr(OFF_STATUS), 32'd1);
        wr(reg_addr(OFF_PRESCALE), 32'd0);
        wr(reg_addr(OFF_COMPARE), 32'd0);
        wr(reg_addr(OFF_COUNT), 32'hFFFF_FFFF);
        wr(reg_addr(OFF_CTRL), 32'd1);
        exp_cnt = '{32'd0, 32'd1, 32'd100, 32'd101, 32'd7};
        exp_st  = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd1};
        for (int i = 0; i < 5; i++) begin
            push($sformatf("wrap_count_%0d", i), exp_cnt[i]);
            push($sformatf("wrap_status_%0d", i), exp_st[i]);
            case (i)
                0, 1: step(1);
                2: wr(reg_addr(OFF_COUNT), 32'd100);
                3: begin
                    wr(reg_addr(OFF_STATUS), 32'd1);
                    wr(reg_addr(OFF_COMPARE), 32'd102);
                    exp_q[exp_q.size()-2].val = 32'd102;
                end
                default: wr(reg_addr(OFF_COUNT), 32'd7);
            endcase
            peek(reg_addr(OFF_COUNT), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            peek(reg_addr(OFF_STATUS), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        wr(reg_addr(OFF_CTRL), 32'd0);
    endtask

    task automatic test_prescale_clear();
        exp_t        e;
        logic [31:0] got;
        wr(reg_addr(OFF_COUNT), 32'd0);
        wr(reg_addr(OFF_PRESCALE), 32'd3);
        wr(reg_addr(OFF_CTRL), 32'd1);
        step(2);
        // Rewriting PRESCALE restarts the divider from 0
        wr(reg_addr(OFF_PRESCALE), 32'd3);
        push("prescale_clear_hold", 32'd0);
        push("prescale_clear_tick", 32'd1);
        step(3);
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        step(1);
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        wr(reg_addr(OFF_CTRL), 32'd0);
    endtask

    task automatic test_gpio_reset();
        exp_t        e;
        logic [31:0] got;
        gpio_in = 8'hA5;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) step(1);
            push($sformatf("gpio_in_edge%0d", n), (n == 2) ? 32'hA5 : 32'h0);
            peek(reg_addr(OFF_GPIO_IN), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        wr(reg_addr(OFF_GPIO_OUT), 32'hFFFF_FF3C);
        wr(reg_addr(OFF_GPIO_IN), 32'h0000_0011);
        push("gpio_out_pin", 32'h3C);
        push("gpio_out_rd", 32'h3C);
        push("gpio_in_readonly", 32'hA5);
        e = exp_q.pop_front();
        n_checks++;
        if (32'(gpio_out) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, gpio_out, e.val);
        end
        peek(reg_addr(OFF_GPIO_OUT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        peek(reg_addr(OFF_GPIO_IN), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end

        wr(reg_addr(OFF_STATUS), 32'd1);
        wr(reg_addr(OFF_COUNT), 32'd0);
        wr(reg_addr(OFF_COMPARE), 32'd3);
        wr(reg_addr(OFF_PRESCALE), 32'd0);
        wr(reg_addr(OFF_CTRL), 32'd5);
        step(5);
        push("pre_reset_count", 32'd5);
        push("pre_reset_irq", 32'd1);
        peek(reg_addr(OFF_COUNT), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({31'd0, irq} !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end

        // Mid-cycle reset: no clock edge between assertion and sampling
        areset = 1'b0;
        push("reset_async_irq", 32'd0);
        push("reset_async_gpio_out", 32'd0);
        push("reset_async_count", 32'd0);
        push("reset_async_compare", 32'hFFFF_FFFF);
        push("reset_async_gpio_in", 32'd0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({31'd0, irq} !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (32'(gpio_out) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, gpio_out, e.val);
        end
        for (int i = 0; i < 3; i++) begin
            peek(reg_addr((i == 0) ? OFF_COUNT : (i == 1) ? OFF_COMPARE : OFF_GPIO_IN), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        areset = 1'b1;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        areset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_outside();
        test_prescale();
        test_autoreload_w1c();
        test_w1c_race();
        test_wrap_priority();
        test_prescale_clear();
        test_gpio_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
Memory-mapped responder on the core's data-memory bus (WE/A/WD/RD); it serves loads and stores that the datapath initiates toward addresses outside data RAM.
Contains a prescaled 32-bit timer with compare match, a sticky match flag, an interrupt line, and a GPIO output/input register pair.
The top level muxes RD into the load-result path when hit is high.
Reads are combinational, with the same timing as data memory. Writes commit on the rising clock edge.

Parameters:
BASE_ADDR, 32'h0000_1000, byte base of the 32-byte register window; must be 32-byte aligned.
GPIO_W, 8, width of gpio_out and gpio_in (1..32).

Ports:
clk  input  1  system clock, rising edge.
areset  input  1  asynchronous, active-low reset.
WE  input  1  store strobe from control unit.
A  input  32  byte address (ALU result).
WD  input  32  store data (register-file RD2).
RD  output  32  load data; combinational.
hit  output  1  A lies in the register window; top selects RD when high.
irq  output  1  MATCH & IRQ_EN.
gpio_out  output  GPIO_W  GPIO output register.
gpio_in  input  GPIO_W  asynchronous external inputs.

Behaviour:
- Decode:
  - hit = (A[31:5] == BASE_ADDR[31:5]).
  - Word offset = A[4:2]; A[1:0] is ignored.
  - A write happens only when WE && hit.
- Register map (offset: name, reset value):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; upper bits read 0; reset 0.
  - 0x04 PRESCALE: [15:0]; reset 0.
  - 0x08 COUNT: [31:0], R/W; reset 0.
  - 0x0C COMPARE: [31:0]; reset 32'hFFFF_FFFF.
  - 0x10 STATUS: bit0 MATCH, sticky, write-1-to-clear; reset 0.
  - 0x14 GPIO_OUT: [GPIO_W-1:0]; reset 0.
  - 0x18 GPIO_IN: read-only; returns the synchronized value; writes are ignored.
  - 0x1C: reserved; reads 0, writes ignored.
- RD: when hit, the selected register, zero-extended. When not hit, RD = 0.
- Prescaler:
  - 16-bit pre_cnt; reset 0.
  - While EN=0, pre_cnt is held at 0.
  - While EN=1, tick = (pre_cnt == PRESCALE); on tick pre_cnt <= 0, else pre_cnt <= pre_cnt+1.
  - PRESCALE=0 gives a tick every cycle.
  - Any write to PRESCALE also clears pre_cnt in the same edge.
- Counter, on tick:
  - If COUNT == COMPARE: MATCH <= 1; COUNT <= AUTO_RELOAD ? 0 : COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - Wraps 32'hFFFF_FFFF -> 0 with no flag.
  - Without a tick, COUNT holds.
- Priorities within one cycle:
  - A software write to COUNT overrides the tick update. A match evaluated on the old COUNT in that cycle still sets MATCH.
  - A new match setting MATCH wins over a W1C to STATUS in the same cycle.
  - A write to CTRL takes effect for the next cycle's tick.
- irq: combinational from registered MATCH and IRQ_EN; no glitch paths from bus inputs.
- GPIO_IN: two-flop synchronizer, reset 0. A change on gpio_in is visible on RD two rising edges later.
- Reset: asserting areset at any time (including mid-count) clears every register, pre_cnt and the synchronizer to the values above immediately. irq and gpio_out go low asynchronously.

Decomposition:
- Shared package (mmio_pkg):
  - Register offset constants: OFF_CTRL, OFF_PRESCALE, OFF_COUNT, OFF_COMPARE, OFF_STATUS, OFF_GPIO_OUT, OFF_GPIO_IN.
  - CTRL bit indices: EN, AUTO_RELOAD, IRQ_EN.
  - STATUS_MATCH index.
  - Default BASE_ADDR.
- One natural sub-module: sync_2ff (parameterized width, areset-cleared), reusable for other asynchronous inputs.
- Timer and register file stay in this module.

Test Plan:
1. Reset, then read all 8 offsets -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, GPIO_OUT=0, GPIO_IN=0, 0x1C=0.
2. Access outside the window -> hit=0 and RD=0.
3. Prescaled counting: PRESCALE=3, COMPARE=5, CTRL=5 (EN|IRQ_EN) -> COUNT increments every 4 cycles. After the tick with COUNT=5, MATCH=1 and irq=1. COUNT continues to 6.
4. Auto-reload and W1C: CTRL=3, PRESCALE=0, COMPARE=2 -> COUNT cycles 0,1,2,0,1,2. Write STATUS=1 -> MATCH=0, unless it coincides with a match tick, in which case MATCH stays 1.
5. Priority and wrap: COUNT=FFFF_FFFF, COMPARE=0, EN with PRESCALE=0 -> next COUNT=0 with MATCH=0, then MATCH=1 one tick later. A write COUNT=100 on a tick cycle -> reads 100.
6. GPIO and reset mid-operation: gpio_in=8'hA5 -> RD@0x18=A5 after 2 edges. Write GPIO_OUT=8'h3C -> gpio_out=3C. Assert areset mid-count -> COUNT=0, gpio_out=0, irq=0 immediately.
